// File: rtl/qrs_search_scheduler.sv
// QRS search-window scheduler: refractory blanking, RR-scaled search timeout and
// searchback request handshake around the R-peak detector FSM.
module qrs_search_scheduler #(
    parameter int unsigned CTR_WIDTH       = 24,
    parameter int unsigned DATA_WIDTH      = 11,
    parameter int unsigned REFRACT_SAMPLES = 50,
    parameter int unsigned DEFAULT_RR      = 200
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_ce,
    input  logic [CTR_WIDTH-1:0]  i_ctr,
    input  logic                  i_alg_active,
    input  logic                  i_qrs_search_en,
    input  logic [DATA_WIDTH-1:0] i_rr_period,
    input  logic                  i_rr_period_updated,
    input  logic                  i_extremum_found,
    input  logic                  i_sb_ack,
    input  logic                  i_sb_hit,
    output logic                  o_window_open,
    output logic                  o_sb_req,
    output logic [CTR_WIDTH-1:0]  o_sb_start,
    output logic [CTR_WIDTH-1:0]  o_sb_end,
    output logic [7:0]            o_missed_cnt,
    output logic [1:0]            o_state
);

    localparam int unsigned RefrW = $clog2(REFRACT_SAMPLES + 1);
    localparam logic [RefrW-1:0]     RefrLoad = RefrW'(REFRACT_SAMPLES);
    localparam logic [CTR_WIDTH-1:0] RefrCtr  = CTR_WIDTH'(REFRACT_SAMPLES);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSearch  = 2'd1,
        StRefract = 2'd2,
        StSbWait  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rr_eff_q, rr_eff_d;
    logic [CTR_WIDTH-1:0]  win_start_q, win_start_d;
    logic [CTR_WIDTH-1:0]  last_peak_q, last_peak_d;
    logic [RefrW-1:0]      refr_cnt_q, refr_cnt_d;
    logic [CTR_WIDTH-1:0]  sb_start_q, sb_start_d;
    logic [CTR_WIDTH-1:0]  sb_end_q, sb_end_d;
    logic [7:0]            missed_q, missed_d;

    logic [CTR_WIDTH-1:0]  rr_ext;
    logic [CTR_WIDTH-1:0]  timeout;
    logic [CTR_WIDTH-1:0]  elapsed;

    // ~1.625 * RR; modular subtraction keeps elapsed correct across counter wrap
    assign rr_ext  = CTR_WIDTH'(rr_eff_q);
    assign timeout = rr_ext + (rr_ext >> 1) + (rr_ext >> 3);
    assign elapsed = i_ctr - win_start_q;

    always_comb begin
        state_d     = state_q;
        rr_eff_d    = rr_eff_q;
        win_start_d = win_start_q;
        last_peak_d = last_peak_q;
        refr_cnt_d  = refr_cnt_q;
        sb_start_d  = sb_start_q;
        sb_end_d    = sb_end_q;
        missed_d    = missed_q;

        if (i_rr_period_updated && (i_rr_period != '0)) begin
            rr_eff_d = i_rr_period;
        end

        if (!i_alg_active) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_qrs_search_en) begin
                        win_start_d = i_ctr;
                        state_d     = StSearch;
                    end
                end
                StSearch: begin
                    if (i_extremum_found) begin
                        last_peak_d = i_ctr;
                        refr_cnt_d  = RefrLoad;
                        state_d     = StRefract;
                    end else if (i_ce && (elapsed >= timeout)) begin
                        sb_start_d = last_peak_q + RefrCtr;
                        sb_end_d   = i_ctr;
                        state_d    = StSbWait;
                    end
                end
                StRefract: begin
                    if (i_ce) begin
                        refr_cnt_d = refr_cnt_q - RefrW'(1);
                        if (refr_cnt_q == RefrW'(1)) begin
                            win_start_d = i_ctr + CTR_WIDTH'(1);
                            state_d     = StSearch;
                        end
                    end
                end
                StSbWait: begin
                    if (i_sb_ack) begin
                        if (i_sb_hit) begin
                            last_peak_d = i_ctr;
                            refr_cnt_d  = RefrLoad;
                            state_d     = StRefract;
                        end else begin
                            if (missed_q != 8'hFF) begin
                                missed_d = missed_q + 8'd1;
                            end
                            win_start_d = i_ctr;
                            state_d     = StSearch;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= StIdle;
            rr_eff_q    <= DATA_WIDTH'(DEFAULT_RR);
            win_start_q <= '0;
            last_peak_q <= '0;
            refr_cnt_q  <= '0;
            sb_start_q  <= '0;
            sb_end_q    <= '0;
            missed_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_eff_q    <= rr_eff_d;
            win_start_q <= win_start_d;
            last_peak_q <= last_peak_d;
            refr_cnt_q  <= refr_cnt_d;
            sb_start_q  <= sb_start_d;
            sb_end_q    <= sb_end_d;
            missed_q    <= missed_d;
        end
    end

    assign o_window_open = (state_q == StSearch);
    assign o_sb_req      = (state_q == StSbWait);
    assign o_sb_start    = sb_start_q;
    assign o_sb_end      = sb_end_q;
    assign o_missed_cnt  = missed_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_qrs_search_scheduler.sv
// Scoreboard bench: stimulus queues each expected output change with the counter value
// of the edge that should cause it; the monitor pops on every observed output change.
module tb_qrs_search_scheduler;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ce;
    logic [23:0] ctr;
    logic        alg_active;
    logic        search_en;
    logic [10:0] rr;
    logic        rr_upd;
    logic        extremum;
    logic        sb_ack;
    logic        sb_hit;
    logic        window_open;
    logic        sb_req;
    logic [23:0] sb_start;
    logic [23:0] sb_end;
    logic [7:0]  missed;
    logic [1:0]  state;

    typedef struct packed {
        logic [1:0]  st;
        logic        win;
        logic        req;
        logic [23:0] s;
        logic [23:0] e;
        logic [7:0]  miss;
    } out_t;

    out_t        exp_q[$];
    logic [23:0] at_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b1;

    always #5 clk = ~clk;

    qrs_search_scheduler #(
        .CTR_WIDTH      (24),
        .DATA_WIDTH     (11),
        .REFRACT_SAMPLES(50),
        .DEFAULT_RR     (200)
    ) dut (
        .i_clk              (clk),
        .i_nrst             (nrst),
        .i_ce               (ce),
        .i_ctr              (ctr),
        .i_alg_active       (alg_active),
        .i_qrs_search_en    (search_en),
        .i_rr_period        (rr),
        .i_rr_period_updated(rr_upd),
        .i_extremum_found   (extremum),
        .i_sb_ack           (sb_ack),
        .i_sb_hit           (sb_hit),
        .o_window_open      (window_open),
        .o_sb_req           (sb_req),
        .o_sb_start         (sb_start),
        .o_sb_end           (sb_end),
        .o_missed_cnt       (missed),
        .o_state            (state)
    );

    task automatic expect_evt(input logic [1:0] st, input logic win, input logic req,
                              input logic [23:0] s, input logic [23:0] e,
                              input logic [7:0] m, input logic [23:0] at);
        out_t o;
        o.st = st; o.win = win; o.req = req; o.s = s; o.e = e; o.miss = m;
        exp_q.push_back(o);
        at_q.push_back(at);
    endtask

    // One clock; single-cycle pulses are cleared after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        ce = 1'b0; extremum = 1'b0; sb_ack = 1'b0; sb_hit = 1'b0; rr_upd = 1'b0;
    endtask

    task automatic strobe();
        ce = 1'b1;
        step();
        ctr = ctr + 24'd1;
    endtask

    // Monitor: compare on every change of the visible outputs.
    initial begin
        out_t        cur, prev, exp;
        logic [23:0] prev_ctr, exp_at;
        logic        first;
        first    = 1'b1;
        prev_ctr = '0;
        prev     = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur.st = state; cur.win = window_open; cur.req = sb_req;
                cur.s = sb_start; cur.e = sb_end; cur.miss = missed;
                if (first || (cur != prev)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: got st=%0d win=%0b req=%0b s=%0d e=%0d miss=%0d after ctr=%0d, required no change",
                                 cur.st, cur.win, cur.req, cur.s, cur.e, cur.miss, prev_ctr);
                    end else begin
                        exp    = exp_q.pop_front();
                        exp_at = at_q.pop_front();
                        if ((cur != exp) || (prev_ctr != exp_at)) begin
                            errors++;
                            $display("FAIL evt%0d: got st=%0d win=%0b req=%0b s=%0d e=%0d miss=%0d at ctr=%0d, required st=%0d win=%0b req=%0b s=%0d e=%0d miss=%0d at ctr=%0d",
                                     checks, cur.st, cur.win, cur.req, cur.s, cur.e, cur.miss,
                                     prev_ctr, exp.st, exp.win, exp.req, exp.s, exp.e, exp.miss,
                                     exp_at);
                        end
                    end
                    first = 1'b0;
                    prev  = cur;
                end
                prev_ctr = ctr;
            end
        end
    end

    initial begin
        nrst = 1'b0; ce = 1'b0; ctr = '0; alg_active = 1'b0; search_en = 1'b0;
        rr = '0; rr_upd = 1'b0; extremum = 1'b0; sb_ack = 1'b0; sb_hit = 1'b0;
        expect_evt(2'd0, 1'b0, 1'b0, 24'd0, 24'd0, 8'd0, 24'd0);
        repeat (2) step();
        nrst = 1'b1;
        step();

        // Window opens at ctr=1000
        ctr = 24'd1000; alg_active = 1'b1; search_en = 1'b1;
        expect_evt(2'd1, 1'b1, 1'b0, 24'd0, 24'd0, 8'd0, 24'd1000);
        step();
        rr = 11'd200; rr_upd = 1'b1;
        step();
        while (ctr != 24'd1100) begin
            step();
            strobe();
        end

        // Peak at 1100, 50 strobes of blanking with ignored extremum pulses
        expect_evt(2'd2, 1'b0, 1'b0, 24'd0, 24'd0, 8'd0, 24'd1100);
        extremum = 1'b1;
        step();
        expect_evt(2'd1, 1'b1, 1'b0, 24'd0, 24'd0, 8'd0, 24'd1149);
        for (int i = 0; i < 50; i++) begin
            if ((i % 10) == 5) extremum = 1'b1;
            step();
            if (i == 20) extremum = 1'b1;
            strobe();
        end

        // Timeout 325 after win_start=1150
        expect_evt(2'd3, 1'b0, 1'b1, 24'd1150, 24'd1475, 8'd0, 24'd1475);
        repeat (326) begin
            step();
            strobe();
        end
        repeat (3) step();
        expect_evt(2'd1, 1'b1, 1'b0, 24'd1150, 24'd1475, 8'd1, 24'd1476);
        sb_ack = 1'b1; sb_hit = 1'b0;
        step();

        // Counter wrap; zero RR update ignored
        expect_evt(2'd0, 1'b0, 1'b0, 24'd1150, 24'd1475, 8'd1, 24'd1476);
        alg_active = 1'b0;
        step();
        ctr = 24'hFFFF9C; alg_active = 1'b1; rr = 11'd0; rr_upd = 1'b1;
        expect_evt(2'd1, 1'b1, 1'b0, 24'd1150, 24'd1475, 8'd1, 24'hFFFF9C);
        step();
        expect_evt(2'd3, 1'b0, 1'b1, 24'd1150, 24'd225, 8'd1, 24'd225);
        repeat (326) begin
            step();
            strobe();
        end
        expect_evt(2'd2, 1'b0, 1'b0, 24'd1150, 24'd225, 8'd1, 24'd226);
        sb_ack = 1'b1; sb_hit = 1'b1;
        step();

        // Extremum and timeout together: extremum wins
        expect_evt(2'd0, 1'b0, 1'b0, 24'd1150, 24'd225, 8'd1, 24'd226);
        alg_active = 1'b0;
        step();
        ctr = 24'd5000; alg_active = 1'b1;
        expect_evt(2'd1, 1'b1, 1'b0, 24'd1150, 24'd225, 8'd1, 24'd5000);
        step();
        ctr = 24'd5325; ce = 1'b1; extremum = 1'b1;
        expect_evt(2'd2, 1'b0, 1'b0, 24'd1150, 24'd225, 8'd1, 24'd5325);
        step();
        repeat (3) step();
        expect_evt(2'd0, 1'b0, 1'b0, 24'd1150, 24'd225, 8'd1, 24'd5325);
        alg_active = 1'b0;
        step();

        // RR=100 -> timeout 162; stray ack in SEARCH ignored
        rr = 11'd100; rr_upd = 1'b1;
        step();
        ctr = 24'd6000; alg_active = 1'b1;
        expect_evt(2'd1, 1'b1, 1'b0, 24'd1150, 24'd225, 8'd1, 24'd6000);
        step();
        ctr = 24'd6161; sb_ack = 1'b1; sb_hit = 1'b0;
        step();
        ce = 1'b1;
        step();
        ctr = 24'd6162; ce = 1'b1;
        expect_evt(2'd3, 1'b0, 1'b1, 24'd5375, 24'd6162, 8'd1, 24'd6162);
        step();
        repeat (2) step();

        // Abort while waiting on searchback
        expect_evt(2'd0, 1'b0, 1'b0, 24'd5375, 24'd6162, 8'd1, 24'd6162);
        alg_active = 1'b0;
        step();

        // Asynchronous reset mid-search
        ctr = 24'd7000; alg_active = 1'b1;
        expect_evt(2'd1, 1'b1, 1'b0, 24'd5375, 24'd6162, 8'd1, 24'd7000);
        step();
        step();
        expect_evt(2'd0, 1'b0, 1'b0, 24'd0, 24'd0, 8'd0, 24'd7000);
        nrst = 1'b0;
        repeat (3) step();

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d expected changes never observed, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
